dm_arbiter: RTL
===============

# dm_arbiter

Single-port data-memory arbiter between the CPU pipeline's DM stage and one external requester, such as the image/weight loader. The CPU has fixed priority. A starvation counter forces a one-beat external grant by raising `cpu_stall` into the pipeline hazard logic. The block sits between the CPU's EX_DM-registered memory controls and the synchronous-read data memory.

## Interface
Parameters:
- `AW`, 16: memory address width.
- `DW`, 32: data width.
- `STARVE_LIMIT`, 8: consecutive denied external cycles (≥1) before a forced grant.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cpu_re`, in, 1: CPU load, DM stage.
- `cpu_we`, in, 1: CPU store, DM stage.
- `cpu_addr`, in, AW: CPU address.
- `cpu_wdata`, in, DW: CPU store data.
- `cpu_rdata`, out, DW: equals `mem_rdata`.
- `cpu_stall`, out, 1: pipeline must hold its DM-stage access this cycle.
- `ext_req`, in, 1: external access request.
- `ext_we`, in, 1: 1 means write, 0 means read.
- `ext_addr`, in, AW: external address.
- `ext_wdata`, in, DW: external write data.
- `ext_gnt`, out, 1: external access performed this cycle.
- `ext_rvalid`, out, 1: `ext_rdata` valid this cycle.
- `ext_rdata`, out, DW: equals `mem_rdata`.
- `mem_re`, out, 1: memory read enable.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_rdata`, in, DW: registered memory output, valid one cycle after `mem_re`.

## Operation
- State register `st ∈ {ARB_CPU, ARB_FORCE}`. Counter `starve_cnt` has width `$clog2(STARVE_LIMIT+1)`. Register `ext_rd_q` tracks external reads.
- `cpu_acc = cpu_re | cpu_we`. If both are high, the access is treated as a write (`mem_re=0`).
- **ARB_CPU**, the CPU owns the port:
  - If `cpu_acc`: mem signals are driven from the CPU fields and `ext_gnt=0`.
  - Else if `ext_req`: mem signals are driven from the ext fields (`mem_we=ext_we`, `mem_re=!ext_we`) and `ext_gnt=1`.
  - Otherwise all enables are 0. Address and wdata then carry the CPU fields.
- Starvation counting in ARB_CPU:
  - `ext_req & !ext_gnt`: `starve_cnt` increments, saturating at STARVE_LIMIT.
  - `ext_gnt`, or `!ext_req`: `starve_cnt` clears to 0.
  - `ext_req & !ext_gnt & starve_cnt==STARVE_LIMIT-1`: next state is ARB_FORCE.
- **ARB_FORCE**, the external requester owns the port:
  - `cpu_stall=1`, a Moore output decoded from `st`. CPU inputs are ignored; the pipeline re-presents its access later.
  - If `ext_req`: ext is granted as above, then next state is ARB_CPU and `starve_cnt=0`.
  - If `!ext_req` (protocol violation): no grant, all enables are 0, next state is ARB_CPU and `starve_cnt=0`. `cpu_stall` was still 1 that cycle.
- External protocol:
  - `ext_req`, `ext_we`, `ext_addr` and `ext_wdata` are held stable until the cycle `ext_gnt=1`.
  - Grant is combinational, in the same cycle.
  - Request may be deasserted the cycle after the grant, or held to request a new beat.
- `ext_rd_q <= ext_gnt & !ext_we`, and `ext_rvalid = ext_rd_q`.
- `cpu_rdata` is valid the cycle after a CPU read is performed. The CPU owns interpreting it, because the pipeline's existing one-cycle load timing is unchanged.
- No external write can be lost or duplicated. Each `ext_gnt` equals exactly one memory operation.

## Timing
- Reset values:
  - `st=ARB_CPU`, `starve_cnt=0`, `ext_rd_q=0`.
  - `cpu_stall=0`, `ext_rvalid=0`.
  - `ext_gnt`, `mem_re` and `mem_we` are combinational and 0 whenever there are no requests.
- Latency:
  - Grant to memory operation: 0 cycles.
  - Read data: 1 cycle after grant, for both requesters.
- Worst-case external wait under continuous CPU traffic: STARVE_LIMIT denied cycles, with the grant in cycle STARVE_LIMIT (0-based).
- `cpu_stall` is high for exactly one cycle per forced grant.
- Reset asserted in any state returns to ARB_CPU immediately. Any pending `ext_rvalid` is dropped, and the requester re-issues.
- With STARVE_LIMIT=1, a single denied cycle enters ARB_FORCE.

## Test plan
- **Reset:** assert `rst_n=0` mid-traffic. Required: `cpu_stall=0`, `ext_rvalid=0`, `ext_gnt=0`, no mem enables.
- **CPU only:** write 0x0010←0xDEADBEEF, then read 0x0010. Required: `mem_we=1` in cycle 0, `mem_re=1` in cycle 1, `cpu_rdata=0xDEADBEEF` in cycle 2.
- **External only:** CPU idle, `ext_req` read of 0x0020 holding 0x12345678. Required: `ext_gnt=1` in the same cycle, then `ext_rvalid=1` with `ext_rdata=0x12345678` in the next cycle.
- **Conflict:** CPU accesses every cycle and `ext_req` write 0x0030←0xA5A5A5A5 is held from cycle 0, with STARVE_LIMIT=8. Required:
  - `ext_gnt=0` in cycles 0–7.
  - `cpu_stall=1` and `ext_gnt=1` in cycle 8, with `mem_addr=0x0030`.
  - Cycle 9 is back to CPU with `cpu_stall=0` and `starve_cnt=0`.
- **Request withdrawn in FORCE:** drop `ext_req` in cycle 8. Required: no grant, `cpu_stall=1` for that one cycle only, ARB_CPU in cycle 9.
- **Reset mid-FORCE:** pulse `rst_n` low during cycle 8. Required: after release `cpu_stall=0` and `starve_cnt=0`, and a re-issued `ext_req` again waits 8 cycles under CPU traffic.

Source files
------------

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU DM stage has fixed priority, an external
// requester gets a forced one-beat grant after STARVE_LIMIT denied cycles.
module dm_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } st_t;

  st_t           r_st;
  logic [CW-1:0] r_starve_cnt;
  logic          r_ext_rd_q;

  logic w_cpu_acc;
  logic w_cpu_sel;
  logic w_ext_sel;
  logic w_ext_path;

  assign w_cpu_acc = cpu_re | cpu_we;

  // Enables are gated by rst_n so nothing reaches memory while in reset.
  always_comb begin
    w_cpu_sel = 1'b0;
    w_ext_sel = 1'b0;
    unique case (r_st)
      ARB_CPU: begin
        w_cpu_sel = rst_n & w_cpu_acc;
        w_ext_sel = rst_n & ~w_cpu_acc & ext_req;
      end
      ARB_FORCE: begin
        w_ext_sel = rst_n & ext_req;
      end
      default: begin
        w_cpu_sel = 1'b0;
        w_ext_sel = 1'b0;
      end
    endcase
  end

  assign w_ext_path = w_ext_sel | (r_st == ARB_FORCE);

  assign ext_gnt    = w_ext_sel;
  assign mem_we     = w_ext_sel ? ext_we  : (w_cpu_sel & cpu_we);
  assign mem_re     = w_ext_sel ? ~ext_we : (w_cpu_sel & ~cpu_we);
  assign mem_addr   = w_ext_path ? ext_addr  : cpu_addr;
  assign mem_wdata  = w_ext_path ? ext_wdata : cpu_wdata;

  assign cpu_stall  = (r_st == ARB_FORCE);
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign ext_rvalid = r_ext_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st         <= ARB_CPU;
      r_starve_cnt <= '0;
      r_ext_rd_q   <= 1'b0;
    end else begin
      r_ext_rd_q <= w_ext_sel & ~ext_we;
      unique case (r_st)
        ARB_CPU: begin
          if (ext_req && !w_ext_sel) begin
            if (r_starve_cnt != LIM)
              r_starve_cnt <= r_starve_cnt + CW'(1);
            if (r_starve_cnt == LIM_M1)
              r_st <= ARB_FORCE;
          end else begin
            r_starve_cnt <= '0;
          end
        end
        ARB_FORCE: begin
          r_st         <= ARB_CPU;
          r_starve_cnt <= '0;
        end
        default: begin
          r_st         <= ARB_CPU;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule
